// File: rtl/instr_exec_if.sv
// rtl/instr_exec_if.sv - instruction handshake, result, redirect and status bundle of the execute stage
interface instr_exec_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 5
);
    logic              instr_valid;
    logic [15:0]       instr;
    logic              instr_ready;
    logic [DATA_W-1:0] out;
    logic              out_valid;
    logic              br_valid;
    logic [PC_W-1:0]   br_target;
    logic              zero;
    logic              carry;
    logic              halted;
    logic              illegal;

    modport master (
        output instr_valid, instr,
        input  instr_ready, out, out_valid, br_valid, br_target, zero, carry, halted, illegal
    );

    modport slave (
        input  instr_valid, instr,
        output instr_ready, out, out_valid, br_valid, br_target, zero, carry, halted, illegal
    );
endinterface

// File: rtl/instr_exec.sv
// rtl/instr_exec.sv - accumulator execute stage fed by the fetch counter
// EXEC_MUL_EN enables the iterative shift-add MUL; otherwise opcode 0C is illegal.
module instr_exec #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 5
) (
    input  logic         clk,
    input  logic         rst,
    instr_exec_if.slave  bus
);
    localparam logic [7:0] OP_NOP  = 8'h00, OP_LDI = 8'h01, OP_ADDI = 8'h02, OP_SUBI = 8'h03,
                           OP_ANDI = 8'h04, OP_ORI = 8'h05, OP_XORI = 8'h06, OP_SHL  = 8'h07,
                           OP_SHR  = 8'h08, OP_OUT = 8'h09, OP_JZ   = 8'h0A, OP_JMP  = 8'h0B,
                           OP_MUL  = 8'h0C, OP_HALT = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef EXEC_MUL_EN
        S_MUL  = 2'd1,
`endif
        S_HALT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [7:0]        op;
    logic [DATA_W-1:0] imm;
    logic              accept;
    logic [DATA_W-1:0] acc, acc_nxt;
    logic              acc_we, carry_q, carry_nxt, carry_we, zero_q, illegal_op;
    logic [DATA_W:0]   add_w, sub_w, shl_w, shr_w;
    logic [2:0]        sh;

    assign op     = bus.instr[15:8];
    assign imm    = DATA_W'(bus.instr[7:0]);
    assign sh     = bus.instr[2:0];
    assign accept = bus.instr_valid && (state == S_IDLE);

    // The extra top/bottom bit of each shift captures the last bit shifted out.
    assign add_w = {1'b0, acc} + {1'b0, imm};
    assign sub_w = {1'b0, acc} - {1'b0, imm};
    assign shl_w = {1'b0, acc} << sh;
    assign shr_w = {acc, 1'b0} >> sh;

`ifdef EXEC_MUL_EN
    localparam int CNT_W = $clog2(DATA_W) + 1;
    logic [2*DATA_W-1:0] mcand, prod, prod_step;
    logic [DATA_W-1:0]   mplier;
    logic [CNT_W-1:0]    cnt;
    logic                mul_last;

    assign prod_step = mplier[0] ? prod + mcand : prod;
    assign mul_last  = (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
        end else if (accept && op == OP_MUL) begin
            mcand  <= {{DATA_W{1'b0}}, acc};
            mplier <= imm;
            prod   <= '0;
            cnt    <= '0;
        end else if (state == S_MUL) begin
            prod   <= prod_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && op == OP_HALT) state_nxt = S_HALT;
`ifdef EXEC_MUL_EN
                else if (accept && op == OP_MUL) state_nxt = S_MUL;
`endif
            end
`ifdef EXEC_MUL_EN
            S_MUL:   if (mul_last) state_nxt = S_IDLE;
`endif
            default: state_nxt = S_HALT;
        endcase
    end

    always_comb begin
        bus.instr_ready = (state == S_IDLE);
    end

    always_comb begin
        acc_nxt    = acc;
        acc_we     = 1'b0;
        carry_nxt  = carry_q;
        carry_we   = 1'b0;
        illegal_op = 1'b0;
        if (accept) begin
            case (op)
                OP_LDI:  begin acc_nxt = imm;               acc_we = 1'b1; end
                OP_ADDI: begin acc_nxt = add_w[DATA_W-1:0]; acc_we = 1'b1;
                               carry_nxt = add_w[DATA_W];   carry_we = 1'b1; end
                OP_SUBI: begin acc_nxt = sub_w[DATA_W-1:0]; acc_we = 1'b1;
                               carry_nxt = sub_w[DATA_W];   carry_we = 1'b1; end
                OP_ANDI: begin acc_nxt = acc & imm;         acc_we = 1'b1; end
                OP_ORI:  begin acc_nxt = acc | imm;         acc_we = 1'b1; end
                OP_XORI: begin acc_nxt = acc ^ imm;         acc_we = 1'b1; end
                OP_SHL:  begin acc_nxt = shl_w[DATA_W-1:0]; acc_we = 1'b1;
                               carry_nxt = shl_w[DATA_W];   carry_we = (sh != 3'd0); end
                OP_SHR:  begin acc_nxt = shr_w[DATA_W:1];   acc_we = 1'b1;
                               carry_nxt = shr_w[0];        carry_we = (sh != 3'd0); end
`ifdef EXEC_MUL_EN
                OP_MUL:  ;
`else
                OP_MUL:  illegal_op = 1'b1;
`endif
                OP_NOP, OP_OUT, OP_JZ, OP_JMP, OP_HALT: ;
                default: illegal_op = 1'b1;
            endcase
        end
`ifdef EXEC_MUL_EN
        if (state == S_MUL && mul_last) begin
            acc_nxt   = prod_step[DATA_W-1:0];
            acc_we    = 1'b1;
            carry_nxt = |prod_step[2*DATA_W-1:DATA_W];
            carry_we  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc           <= '0;
            zero_q        <= 1'b1;
            carry_q       <= 1'b0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.br_valid  <= 1'b0;
            bus.br_target <= '0;
            bus.halted    <= 1'b0;
            bus.illegal   <= 1'b0;
        end else begin
            bus.out_valid <= accept && op == OP_OUT;
            bus.br_valid  <= accept && (op == OP_JMP || (op == OP_JZ && zero_q));
            if (accept && op == OP_OUT) bus.out <= acc;
            if (accept && (op == OP_JMP || (op == OP_JZ && zero_q)))
                bus.br_target <= bus.instr[PC_W-1:0];
            if (acc_we) begin
                acc    <= acc_nxt;
                zero_q <= (acc_nxt == '0);
            end
            if (carry_we) carry_q <= carry_nxt;
            if (accept && op == OP_HALT) bus.halted <= 1'b1;
            if (illegal_op) bus.illegal <= 1'b1;
        end
    end

    assign bus.zero  = zero_q;
    assign bus.carry = carry_q;
endmodule

// File: tb/tb_instr_exec.sv
// tb/tb_instr_exec.sv - random and directed checks of instr_exec against an architectural model
module tb_instr_exec;
    localparam int DW = 8;
    localparam int PW = 5;
    localparam longint M = 64'd1 << DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    instr_exec_if #(.DATA_W(DW), .PC_W(PW)) bus ();
    instr_exec #(.DATA_W(DW), .PC_W(PW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    longint m_acc, m_out, m_bt;
    bit     m_carry, m_halted, m_illegal, m_busy, exp_ov, exp_bv;
    int     exp_stall;

    task automatic model_reset();
        m_acc = 0; m_out = 0; m_bt = 0; m_carry = 0; m_halted = 0; m_illegal = 0;
        m_busy = 0; exp_ov = 0; exp_bv = 0; exp_stall = 0;
    endtask

    task automatic model_step(input logic [15:0] w);
        longint imm, p;
        int     s;
        imm = longint'(w[7:0]);
        s = int'(w[2:0]);
        exp_ov = 0; exp_bv = 0; m_busy = 0;
        case (w[15:8])
            8'h00: ;
            8'h01: m_acc = imm;
            8'h02: begin m_carry = (m_acc + imm) >= M; m_acc = (m_acc + imm) % M; end
            8'h03: begin m_carry = imm > m_acc; m_acc = (m_acc - imm + M) % M; end
            8'h04: m_acc = m_acc & imm;
            8'h05: m_acc = m_acc | imm;
            8'h06: m_acc = m_acc ^ imm;
            8'h07: begin if (s != 0) m_carry = ((m_acc >> (DW - s)) & 1) != 0; m_acc = (m_acc << s) % M; end
            8'h08: begin if (s != 0) m_carry = ((m_acc >> (s - 1)) & 1) != 0; m_acc = m_acc >> s; end
            8'h09: begin m_out = m_acc; exp_ov = 1; end
            8'h0A: if (m_acc == 0) begin exp_bv = 1; m_bt = imm % 32; end
            8'h0B: begin exp_bv = 1; m_bt = imm % 32; end
`ifdef EXEC_MUL_EN
            8'h0C: begin p = m_acc * imm; m_acc = p % M; m_carry = p >= M; m_busy = 1; exp_stall = DW; end
`else
            8'h0C: m_illegal = 1;
`endif
            8'hFF: m_halted = 1;
            default: m_illegal = 1;
        endcase
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic exec(input logic [15:0] w);
        int n;
        bus.instr = w;
        bus.instr_valid = 1'b1;
        n = 0;
        while (!bus.instr_ready && n < 64) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != exp_stall) begin failures++; $display("FAIL stall_cycles op=%h got=%0d exp=%0d", w[15:8], n, exp_stall); end
        checks++;
        if ({bus.zero, bus.carry} !== {m_acc == 0, m_carry}) begin
            failures++; $display("FAIL pre_flags op=%h got=%b%b exp=%b%b", w[15:8], bus.zero, bus.carry, m_acc == 0, m_carry);
        end
        exp_stall = 0;
        model_step(w);
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        checks++;
        if (bus.out_valid !== exp_ov) begin failures++; $display("FAIL out_valid op=%h got=%b exp=%b", w[15:8], bus.out_valid, exp_ov); end
        checks++;
        if (bus.br_valid !== exp_bv) begin failures++; $display("FAIL br_valid op=%h got=%b exp=%b", w[15:8], bus.br_valid, exp_bv); end
        if (exp_bv) begin
            checks++;
            if (bus.br_target !== PW'(m_bt)) begin failures++; $display("FAIL br_target got=%h exp=%h", bus.br_target, PW'(m_bt)); end
        end
        checks++;
        if (bus.out !== DW'(m_out)) begin failures++; $display("FAIL out op=%h got=%h exp=%h", w[15:8], bus.out, DW'(m_out)); end
        checks++;
        if ({bus.illegal, bus.halted} !== {m_illegal, m_halted}) begin
            failures++; $display("FAIL sticky op=%h got=%b%b exp=%b%b", w[15:8], bus.illegal, bus.halted, m_illegal, m_halted);
        end
        checks++;
        if (bus.instr_ready !== !(m_busy || m_halted)) begin
            failures++; $display("FAIL ready_after op=%h got=%b exp=%b", w[15:8], bus.instr_ready, !(m_busy || m_halted));
        end
        if (!m_busy) begin
            checks++;
            if ({bus.zero, bus.carry} !== {m_acc == 0, m_carry}) begin
                failures++; $display("FAIL flags op=%h got=%b%b exp=%b%b", w[15:8], bus.zero, bus.carry, m_acc == 0, m_carry);
            end
        end
    endtask

    task automatic test_reset();
        bus.instr_valid = 1'b0;
        bus.instr = 16'h0000;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.out, bus.out_valid, bus.br_valid, bus.br_target, bus.zero, bus.carry, bus.halted, bus.illegal, bus.instr_ready}
            !== {8'h00, 1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failures++; $display("FAIL reset_values got=%h", {bus.out, bus.out_valid, bus.br_valid, bus.br_target, bus.zero, bus.carry, bus.halted, bus.illegal, bus.instr_ready});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_arith();
        exec(16'h01F0);
        exec(16'h0220);
        exec(16'h0900);
        checks++;
        if ({bus.out, bus.carry, bus.zero} !== {8'h10, 1'b1, 1'b0}) begin
            failures++; $display("FAIL addi_out got=%h/%b/%b exp=10/1/0", bus.out, bus.carry, bus.zero);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL out_valid_width got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_branch();
        exec(16'h0105);
        exec(16'h0305);
        exec(16'h0A13);
        checks++;
        if ({bus.br_valid, bus.br_target} !== {1'b1, 5'h13}) begin
            failures++; $display("FAIL jz_taken got=%b/%h exp=1/13", bus.br_valid, bus.br_target);
        end
        exec(16'h0101);
        exec(16'h0A03);
        checks++;
        if (bus.br_valid !== 1'b0) begin failures++; $display("FAIL jz_not_taken got=%b exp=0", bus.br_valid); end
        exec(16'h0BFF);
    endtask

    task automatic test_illegal();
        exec(16'h0142);
        exec(16'h7E99);
        exec(16'h0900);
        checks++;
        if ({bus.illegal, bus.out} !== {1'b1, 8'h42}) begin
            failures++; $display("FAIL illegal_op got=%b/%h exp=1/42", bus.illegal, bus.out);
        end
    endtask

    task automatic test_mul();
        exec(16'h0112);
        exec(16'h0C10);
        exec(16'h0201);
        exec(16'h0900);
        checks++;
`ifdef EXEC_MUL_EN
        if (bus.out !== 8'h21) begin failures++; $display("FAIL mul_once got=%h exp=21", bus.out); end
`else
        if ({bus.out, bus.illegal} !== {8'h13, 1'b1}) begin failures++; $display("FAIL mul_disabled got=%h/%b exp=13/1", bus.out, bus.illegal); end
`endif
    endtask

    task automatic test_random();
        logic [7:0] op;
        int r;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 14);
            if (r <= 12)      op = 8'(r);
            else if (r == 13) op = 8'(8'h0D + $urandom_range(0, 8'hF0));
            else              op = 8'h09;
            exec({op, 8'($urandom)});
            if (exp_stall == 0 && $urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        exec(16'h0155);
        exec(16'h0900);
        exec(16'h7E00);
        exec(16'h0B1F);
        exec(16'h01FF);
        exec(16'h0202);
        exec(16'h0C05);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.out, bus.out_valid, bus.br_valid, bus.br_target, bus.zero, bus.carry, bus.halted, bus.illegal, bus.instr_ready}
            !== {8'h00, 1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failures++; $display("FAIL async_reset got=%h", {bus.out, bus.out_valid, bus.br_valid, bus.br_target, bus.zero, bus.carry, bus.halted, bus.illegal, bus.instr_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        exec(16'h0900);
        checks++;
        if ({bus.out, bus.out_valid, bus.zero} !== {8'h00, 1'b1, 1'b1}) begin
            failures++; $display("FAIL acc_after_reset got=%h/%b/%b exp=00/1/1", bus.out, bus.out_valid, bus.zero);
        end
    endtask

    task automatic test_halt();
        int ready_seen, ov_seen;
        exec(16'h0133);
        exec(16'hFF00);
        bus.instr = 16'h0177;
        bus.instr_valid = 1'b1;
        ready_seen = 0;
        ov_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.instr_ready) ready_seen++;
            if (bus.out_valid || bus.br_valid) ov_seen++;
        end
        checks++;
        if (ready_seen != 0) begin failures++; $display("FAIL halt_ready got=%0d exp=0", ready_seen); end
        checks++;
        if (ov_seen != 0) begin failures++; $display("FAIL halt_pulses got=%0d exp=0", ov_seen); end
        checks++;
        if ({bus.halted, bus.zero} !== {1'b1, 1'b0}) begin
            failures++; $display("FAIL halt_frozen got=%b/%b exp=1/0", bus.halted, bus.zero);
        end
        bus.instr_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if ({bus.halted, bus.instr_ready} !== 2'b01) begin
            failures++; $display("FAIL halt_release got=%b%b exp=01", bus.halted, bus.instr_ready);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_branch();
        test_illegal();
        test_mul();
        test_random();
        test_reset_mid();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
